zigbee_fifo_tx: RTL and testbench

// - APB-written byte FIFO feeding a bit serializer in the Zigbee TX path.
// - CPU pushes bytes over APB; when en_IQ is set, bytes pop in order and go out MSB-first on data_out.
// - IQ_rate strobes each new bit. The downstream bit-stream decoder rebuilds bytes from data_out/IQ_rate.

---
 rtl/zigbee_fifo_tx.sv | 143 ++++++++++++++
 tb/tb_zigbee_fifo_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zigbee_fifo_tx.sv
// APB-written byte FIFO feeding an MSB-first bit serializer for the Zigbee TX path.
// Define FIFO_TX_OVERFLOW_ERR_EN to flag refused (FIFO full) writes on pslverr.
module zigbee_fifo_tx #(
  parameter int DEPTH   = 64,
  parameter int BIT_DIV = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pwdata,
  input  logic       psel,
  input  logic       pwrite,
  input  logic       penable,
  input  logic       en_IQ,
  output logic       pready,
  output logic       pslverr,
  output logic       data_out,
  output logic       IQ_rate,
  output logic       mem_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(BIT_DIV);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic            dout_q, dout_d;
  logic            iq_q, iq_d;
  logic            full_q, full_d;

  logic            wr_try;
  logic            full;
  logic            wr_ok;
  logic            pop;
  logic [7:0]      rd_data;

  assign wr_try  = psel & pwrite & penable;
  assign full    = (count_q == CW'(DEPTH));
  assign wr_ok   = wr_try & ~full;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    div_d    = div_q;
    dout_d   = dout_q;
    iq_d     = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        dout_d = 1'b0;
        if (en_IQ && count_q != '0) pop = 1'b1;
      end
      S_SHIFT: begin
        if (div_q == DW'(BIT_DIV - 1)) begin
          div_d = '0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[6:0], 1'b0};
            dout_d  = shift_q[6];
            iq_d    = 1'b1;
          end else if (en_IQ && count_q != '0) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            dout_d  = 1'b0;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
    endcase
    // A pop presents bit7 immediately so back-to-back bytes have no gap
    if (pop) begin
      state_d  = S_SHIFT;
      shift_d  = rd_data;
      dout_d   = rd_data[7];
      iq_d     = 1'b1;
      bit_d    = 3'd0;
      div_d    = '0;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    count_d = count_q + CW'(wr_ok) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shift_q  <= '0;
      bit_q    <= '0;
      div_q    <= '0;
      dout_q   <= 1'b0;
      iq_q     <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      div_q    <= div_d;
      dout_q   <= dout_d;
      iq_q     <= iq_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= pwdata;
  end

  assign pready    = 1'b1;
  assign data_out  = dout_q;
  assign IQ_rate   = iq_q;
  assign mem_state = full_q;

`ifdef FIFO_TX_OVERFLOW_ERR_EN
  assign pslverr = wr_try & full;
`else
  assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_zigbee_fifo_tx.sv
// Bench for zigbee_fifo_tx: byte scoreboard rebuilt from data_out/IQ_rate,
// bit-period timing checks, table vectors and multi-cycle corner sequences.
module tb_zigbee_fifo_tx;

  localparam int DEPTH   = 64;
  localparam int BIT_DIV = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pwdata = '0;
  logic       psel = 1'b0;
  logic       pwrite = 1'b0;
  logic       penable = 1'b0;
  logic       en_IQ = 1'b0;
  logic       pready;
  logic       pslverr;
  logic       data_out;
  logic       IQ_rate;
  logic       mem_state;

  zigbee_fifo_tx #(
    .DEPTH(DEPTH),
    .BIT_DIV(BIT_DIV)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pwdata(pwdata),
    .psel(psel),
    .pwrite(pwrite),
    .penable(penable),
    .en_IQ(en_IQ),
    .pready(pready),
    .pslverr(pslverr),
    .data_out(data_out),
    .IQ_rate(IQ_rate),
    .mem_state(mem_state)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0] expq[$];
  int   pushed = 0;
  int   popped = 0;
  int   cyc = 0;
  int   wr_cyc = 0;
  int   byte_start_cyc = 0;
  int   strobes = 0;
  int   rx_cnt = 0;
  int   since = 0;
  int   bit_idx = 0;
  int   hold_err = 0;
  bit   have_prev = 1'b0;
  bit   expect_cont = 1'b0;
  logic last_bit = 1'b0;
  logic [7:0] shreg = '0;
  logic [7:0] last_rx = '0;
  logic [7:0] exp_b;

  // Decoder/scoreboard: sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    since++;
    if (reset) begin
      bit_idx   = 0;
      have_prev = 1'b0;
      expq.delete();
      pushed    = 0;
      popped    = 0;
    end else if (IQ_rate) begin
      strobes++;
      if (bit_idx == 0) begin
        popped++;
        byte_start_cyc = cyc;
        if (expect_cont && have_prev) check("byte_gap", since, BIT_DIV);
      end else begin
        check("bit_spacing", since, BIT_DIV);
      end
      shreg     = {shreg[6:0], data_out};
      last_bit  = data_out;
      have_prev = 1'b1;
      since     = 0;
      bit_idx++;
      if (bit_idx == 8) begin
        bit_idx = 0;
        rx_cnt++;
        last_rx = shreg;
        if (expq.size() == 0) begin
          check("unexpected_byte", {24'h0, shreg}, 32'hFFFF_FFFF);
        end else begin
          exp_b = expq.pop_front();
          check("rx_byte", shreg, exp_b);
        end
      end
    end else if (have_prev && since < BIT_DIV) begin
      if (data_out !== last_bit) hold_err++;
    end
  end

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_idle();
    psel    = 1'b0;
    pwrite  = 1'b0;
    penable = 1'b0;
  endtask

  // Called at posedge+2; holds the write through the next edge
  task automatic wr(input logic [7:0] b);
    psel    = 1'b1;
    pwrite  = 1'b1;
    penable = 1'b1;
    pwdata  = b;
    wr_cyc  = cyc + 1;
    if (pushed - popped < DEPTH) begin
      expq.push_back(b);
      pushed++;
    end
    sync();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_cnt < n && k < budget) begin
      sync();
      k++;
    end
    check("rx_timeout", rx_cnt >= n, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sync();
    check("rst_data_out", data_out, 0);
    check("rst_iq_rate", IQ_rate, 0);
    check("rst_mem_state", mem_state, 0);
    check("rst_pslverr", pslverr, 0);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] bits;
  } vec_t;

  vec_t tbl[5];
  int   base;
  int   s0;
  int   err;
  logic exp_err;

  initial begin
    tbl[0] = '{8'h3C, 8'b0011_1100};
    tbl[1] = '{8'hA5, 8'b1010_0101};
    tbl[2] = '{8'h00, 8'b0000_0000};
    tbl[3] = '{8'hFF, 8'b1111_1111};
    tbl[4] = '{8'h81, 8'b1000_0001};
`ifdef FIFO_TX_OVERFLOW_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    sync();
    do_reset();
    check("pready", pready, 1);

    // Fill to full, refused 65th write, then drain all 64 in order
    for (int i = 0; i < 64; i++) wr(8'(i));
    bus_idle();
    #1;
    check("full_after_64", mem_state, 1);
    #1;
    psel    = 1'b1;
    pwrite  = 1'b1;
    penable = 1'b1;
    pwdata  = 8'hFF;
    #1;
    check("ovf_pslverr", pslverr, exp_err);
    sync();
    bus_idle();
    #1;
    check("ovf_pslverr_clr", pslverr, 0);
    check("still_full", mem_state, 1);
    #1;
    base = rx_cnt;
    s0   = strobes;
    expect_cont = 1'b1;
    en_IQ = 1'b1;
    wait_rx(base + 64, 64 * 8 * BIT_DIV + 200);
    expect_cont = 1'b0;
    repeat (60) sync();
    check("drain_bytes", rx_cnt - base, 64);
    check("drain_strobes", strobes - s0, 512);
    check("not_full", mem_state, 0);

    // Enabled but empty: line stays quiet
    s0  = strobes;
    err = 0;
    for (int i = 0; i < 100; i++) begin
      sync();
      if (IQ_rate !== 1'b0 || data_out !== 1'b0) err++;
    end
    check("empty_quiet", err, 0);
    check("empty_strobes", strobes - s0, 0);

    // Table vectors: single byte from idle, MSB-first bits and latency
    for (int i = 0; i < 5; i++) begin
      base = rx_cnt;
      wr(tbl[i].din);
      bus_idle();
      wait_rx(base + 1, 8 * BIT_DIV + 50);
      check("tbl_bits", last_rx, tbl[i].bits);
      check("tbl_latency", byte_start_cyc - wr_cyc, 1);
      repeat (40) sync();
    end

    // Writes landing mid-stream: 16 bytes out, no gap
    en_IQ = 1'b0;
    base  = rx_cnt;
    for (int i = 0; i < 8; i++) wr(8'h10 + 8'(i));
    bus_idle();
    en_IQ = 1'b1;
    wait_rx(base + 1, 8 * BIT_DIV + 50);
    expect_cont = 1'b1;
    for (int i = 0; i < 8; i++) wr(8'h80 + 8'(i));
    bus_idle();
    wait_rx(base + 16, 16 * 8 * BIT_DIV + 200);
    expect_cont = 1'b0;
    check("stream_count", rx_cnt - base, 16);
    check("stream_q_empty", expq.size(), 0);
    repeat (40) sync();

    // Reset in the middle of a byte aborts everything
    en_IQ = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
    bus_idle();
    s0 = strobes;
    en_IQ = 1'b1;
    for (int k = 0; k < 400 && strobes < s0 + 3; k++) sync();
    check("mid_reached", strobes >= s0 + 3, 1);
    do_reset();
    s0 = strobes;
    repeat (100) sync();
    check("post_rst_strobes", strobes - s0, 0);
    check("post_rst_dout", data_out, 0);
    check("post_rst_full", mem_state, 0);

    check("hold_violations", hold_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
